// File: rtl/lane_skew_buf_2ln_pkg.sv
// Shared constants for the lane skew buffer: default alignment-marker patterns
// for lanes 0..3 and the delay-counter width helper.
package lane_skew_buf_2ln_pkg;

    localparam logic [63:0] AM_DEFAULT_LN0 = 64'h90_76_47_6F_89_B8_B8_6F;
    localparam logic [63:0] AM_DEFAULT_LN1 = 64'hF0_C4_E6_0F_3B_3B_19_F0;
    localparam logic [63:0] AM_DEFAULT_LN2 = 64'hC5_65_9B_3A_3A_9A_64_C5;
    localparam logic [63:0] AM_DEFAULT_LN3 = 64'hA2_79_3D_5D_5D_86_C2_A2;

    localparam int STAT_W = 8;

    // Width of a tap index for a delay line MAX_SKEW words deep.
    function automatic int calc_delay_w(input int max_skew);
        return (max_skew < 2) ? 1 : $clog2(max_skew);
    endfunction

endpackage

// File: rtl/lane_skew_buf_2ln_if.sv
// Two-lane word stream into and out of the skew buffer.
// Valid-only stream, no backpressure: a word pair moves on every cycle valid is high.
interface lane_skew_buf_2ln_if #(
    parameter int WORD_W = 64
);
    logic              din_valid;
    logic [WORD_W-1:0] din0;
    logic [WORD_W-1:0] din1;
    logic              dout_valid;
    logic [WORD_W-1:0] dout0;
    logic [WORD_W-1:0] dout1;
    logic [1:0]        am_ping;

    modport master (
        output din_valid, din0, din1,
        input  dout_valid, dout0, dout1, am_ping
    );

    modport slave (
        input  din_valid, din0, din1,
        output dout_valid, dout0, dout1, am_ping
    );
endinterface

// File: rtl/lane_skew_line.sv
// Single-lane programmable word delay line with wrapping delay counter and AM detector.
// LANE_SKEW_STATS_EN exposes the current delay and a saturating fallback count.
module lane_skew_line
    import lane_skew_buf_2ln_pkg::*;
#(
    parameter int                WORD_W   = 64,
    parameter int                MAX_SKEW = 16,
    parameter logic [WORD_W-1:0] AM       = WORD_W'(AM_DEFAULT_LN0),
    localparam int               DELAY_W  = calc_delay_w(MAX_SKEW)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              force_zero,
    input  logic              inc,
    input  logic              din_valid,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              am_ping,
    output logic              skew_ovf
`ifdef LANE_SKEW_STATS_EN
    ,
    output logic [DELAY_W-1:0] delay,
    output logic [STAT_W-1:0]  fb_cnt
`endif
);

    localparam logic [DELAY_W-1:0] D_MAX = DELAY_W'(MAX_SKEW - 1);

    logic [DELAY_W-1:0]                d;
    logic [MAX_SKEW-2:0][WORD_W-1:0]   line;
    logic [MAX_SKEW-1:0][WORD_W-1:0]   taps;
    logic [WORD_W-1:0]                 tap;

    // Tap 0 is the incoming word itself, so a delay of 0 costs only the output register.
    assign taps = {line, din};
    assign tap  = taps[d];

    always_ff @(posedge clk) begin
        if (din_valid) begin
            line <= taps[MAX_SKEW-2:0];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            d        <= '0;
            skew_ovf <= 1'b0;
        end else begin
            skew_ovf <= 1'b0;
            if (force_zero) begin
                d <= '0;
            end else if (inc) begin
                if (d == D_MAX) begin
                    d        <= '0;
                    skew_ovf <= 1'b1;
                end else begin
                    d <= d + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dout    <= '0;
            am_ping <= 1'b0;
        end else if (din_valid) begin
            dout    <= tap;
            am_ping <= (tap == AM);
        end else begin
            am_ping <= 1'b0;
        end
    end

`ifdef LANE_SKEW_STATS_EN
    assign delay = d;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            fb_cnt <= '0;
        end else if (force_zero) begin
            fb_cnt <= '0;
        end else if (inc && (fb_cnt != {STAT_W{1'b1}})) begin
            fb_cnt <= fb_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/lane_skew_buf_2ln.sv
// Two-lane skew buffer feeding the deskew lock monitor; fallback requests delay the early lane.
// LANE_SKEW_STATS_EN adds delay0/1 and fb_cnt0/1 observation outputs.
module lane_skew_buf_2ln
    import lane_skew_buf_2ln_pkg::*;
#(
    parameter int                WORD_W   = 64,
    parameter int                MAX_SKEW = 16,
    parameter logic [WORD_W-1:0] AM_LN0   = WORD_W'(AM_DEFAULT_LN0),
    parameter logic [WORD_W-1:0] AM_LN1   = WORD_W'(AM_DEFAULT_LN1),
    localparam int               DELAY_W  = calc_delay_w(MAX_SKEW)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 word_locked,
    input  logic [1:0]           fallback_req,
    lane_skew_buf_2ln_if.slave   bus,
    output logic [1:0]           skew_ovf
`ifdef LANE_SKEW_STATS_EN
    ,
    output logic [DELAY_W-1:0]   delay0,
    output logic [DELAY_W-1:0]   delay1,
    output logic [STAT_W-1:0]    fb_cnt0,
    output logic [STAT_W-1:0]    fb_cnt1
`endif
);

    logic       force_zero;
    logic [1:0] inc;

    // A request on both lanes at once is contradictory and dropped.
    assign force_zero = !word_locked;
    assign inc[0]     = word_locked && fallback_req[0] && !fallback_req[1];
    assign inc[1]     = word_locked && fallback_req[1] && !fallback_req[0];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= bus.din_valid;
        end
    end

    lane_skew_line #(
        .WORD_W   (WORD_W),
        .MAX_SKEW (MAX_SKEW),
        .AM       (AM_LN0)
    ) u_line0 (
        .clk        (clk),
        .arst_n     (arst_n),
        .force_zero (force_zero),
        .inc        (inc[0]),
        .din_valid  (bus.din_valid),
        .din        (bus.din0),
        .dout       (bus.dout0),
        .am_ping    (bus.am_ping[0]),
        .skew_ovf   (skew_ovf[0])
`ifdef LANE_SKEW_STATS_EN
        ,
        .delay      (delay0),
        .fb_cnt     (fb_cnt0)
`endif
    );

    lane_skew_line #(
        .WORD_W   (WORD_W),
        .MAX_SKEW (MAX_SKEW),
        .AM       (AM_LN1)
    ) u_line1 (
        .clk        (clk),
        .arst_n     (arst_n),
        .force_zero (force_zero),
        .inc        (inc[1]),
        .din_valid  (bus.din_valid),
        .din        (bus.din1),
        .dout       (bus.dout1),
        .am_ping    (bus.am_ping[1]),
        .skew_ovf   (skew_ovf[1])
`ifdef LANE_SKEW_STATS_EN
        ,
        .delay      (delay1),
        .fb_cnt     (fb_cnt1)
`endif
    );

endmodule

// File: tb/tb_lane_skew_buf_2ln.sv
// Directed bench for lane_skew_buf_2ln: reset, skew correction, valid gaps, wrap,
// conflict/unlock and (with LANE_SKEW_STATS_EN) the statistics outputs.
module tb_lane_skew_buf_2ln;

    localparam int          WORD_W   = 64;
    localparam int          MAX_SKEW = 16;
    localparam logic [63:0] AM0      = 64'h90_76_47_6F_89_B8_B8_6F;
    localparam logic [63:0] AM1      = 64'hF0_C4_E6_0F_3B_3B_19_F0;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       word_locked = 1'b0;
    logic [1:0] fallback_req = 2'b00;
    logic [1:0] skew_ovf;
`ifdef LANE_SKEW_STATS_EN
    logic [3:0] delay0, delay1;
    logic [7:0] fb_cnt0, fb_cnt1;
`endif

    int checks = 0;
    int failures = 0;

    lane_skew_buf_2ln_if #(.WORD_W(WORD_W)) bus ();

    lane_skew_buf_2ln #(.WORD_W(WORD_W), .MAX_SKEW(MAX_SKEW)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .word_locked  (word_locked),
        .fallback_req (fallback_req),
        .bus          (bus),
        .skew_ovf     (skew_ovf)
`ifdef LANE_SKEW_STATS_EN
        ,
        .delay0       (delay0),
        .delay1       (delay1),
        .fb_cnt0      (fb_cnt0),
        .fb_cnt1      (fb_cnt1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] w0(input int n);
        return {32'h0A0A_0000, 32'(n)};
    endfunction

    function automatic logic [63:0] w1(input int n);
        return {32'h0B0B_0000, 32'(n)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b);
        bus.din_valid = v;
        bus.din0      = a;
        bus.din1      = b;
    endtask

    task automatic drive_gap();
        drive(1'b0, {32'hEEEE_EEEE, $urandom_range(0, 32'hFFFF)}, {32'hDDDD_DDDD, $urandom_range(0, 32'hFFFF)});
    endtask

    task automatic unlock_clear();
        word_locked = 1'b0;
        drive_gap();
        step();
        word_locked = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0);
        step();
        step();
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL rst_dout_valid got=%b exp=0", bus.dout_valid); end
        checks++; if (bus.dout0 !== 64'h0) begin failures++; $display("FAIL rst_dout0 got=%h exp=0", bus.dout0); end
        checks++; if (bus.dout1 !== 64'h0) begin failures++; $display("FAIL rst_dout1 got=%h exp=0", bus.dout1); end
        checks++; if (bus.am_ping !== 2'b00) begin failures++; $display("FAIL rst_am_ping got=%b exp=00", bus.am_ping); end
        checks++; if (skew_ovf !== 2'b00) begin failures++; $display("FAIL rst_skew_ovf got=%b exp=00", skew_ovf); end
        arst_n = 1'b1;
        word_locked = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, w0(i), w1(i));
            step();
            checks++; if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL rst_stream_valid i=%0d got=%b exp=1", i, bus.dout_valid); end
            checks++; if (bus.dout0 !== w0(i)) begin failures++; $display("FAIL rst_stream_dout0 i=%0d got=%h exp=%h", i, bus.dout0, w0(i)); end
            checks++; if (bus.dout1 !== w1(i)) begin failures++; $display("FAIL rst_stream_dout1 i=%0d got=%h exp=%h", i, bus.dout1, w1(i)); end
        end
        drive(1'b1, w0(8), w1(8));
        arst_n = 1'b0;
        #1;
        checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL midrst_dout_valid got=%b exp=0", bus.dout_valid); end
        checks++; if (bus.dout0 !== 64'h0) begin failures++; $display("FAIL midrst_dout0 got=%h exp=0", bus.dout0); end
        checks++; if (bus.am_ping !== 2'b00) begin failures++; $display("FAIL midrst_am_ping got=%b exp=00", bus.am_ping); end
        checks++; if (skew_ovf !== 2'b00) begin failures++; $display("FAIL midrst_skew_ovf got=%b exp=00", skew_ovf); end
        step();
        arst_n = 1'b1;
        for (int i = 10; i < 26; i++) begin
            drive(1'b1, w0(i), w1(i));
            step();
        end
        checks++; if (bus.dout0 !== w0(25)) begin failures++; $display("FAIL flush_dout0 got=%h exp=%h", bus.dout0, w0(25)); end
    endtask

    task automatic test_skew3();
        logic [1:0] exp_ping;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i == 5) ? AM0 : w0(500 + i), (i == 8) ? AM1 : w1(500 + i));
            step();
            exp_ping = {i == 8, i == 5};
            checks++; if (bus.am_ping !== exp_ping) begin failures++; $display("FAIL skew_pre_ping i=%0d got=%b exp=%b", i, bus.am_ping, exp_ping); end
        end
        drive_gap();
        for (int p = 0; p < 3; p++) begin
            fallback_req = 2'b01;
            step();
        end
        fallback_req = 2'b00;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i == 2) ? AM0 : w0(600 + i), (i == 5) ? AM1 : w1(600 + i));
            step();
            exp_ping = (i == 5) ? 2'b11 : 2'b00;
            checks++; if (bus.am_ping !== exp_ping) begin failures++; $display("FAIL skew_post_ping i=%0d got=%b exp=%b", i, bus.am_ping, exp_ping); end
            if (i == 5) begin
                checks++; if (bus.dout0 !== AM0) begin failures++; $display("FAIL skew_post_dout0 got=%h exp=%h", bus.dout0, AM0); end
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic        vld [6];
        int          wrd [6];
        int          e0  [6];
        int          e1  [6];
        unlock_clear();
        for (int n = 100; n < 105; n++) begin
            drive(1'b1, w0(n), w1(n));
            step();
            checks++; if (bus.dout0 !== w0(n)) begin failures++; $display("FAIL gap_d0_dout0 n=%0d got=%h exp=%h", n, bus.dout0, w0(n)); end
        end
        drive_gap();
        fallback_req = 2'b01;
        step();
        fallback_req = 2'b00;
        drive(1'b1, w0(105), w1(105));
        step();
        checks++; if (bus.dout0 !== w0(104)) begin failures++; $display("FAIL gap_dup1_dout0 got=%h exp=%h", bus.dout0, w0(104)); end
        checks++; if (bus.dout1 !== w1(105)) begin failures++; $display("FAIL gap_dup1_dout1 got=%h exp=%h", bus.dout1, w1(105)); end
        drive_gap();
        fallback_req = 2'b01;
        step();
        fallback_req = 2'b00;
        drive(1'b1, w0(106), w1(106));
        step();
        checks++; if (bus.dout0 !== w0(104)) begin failures++; $display("FAIL gap_dup2_dout0 got=%h exp=%h", bus.dout0, w0(104)); end
        vld = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        wrd = '{200, 0, 201, 202, 0, 203};
        e0  = '{105, 105, 106, 200, 200, 201};
        e1  = '{200, 200, 201, 202, 202, 203};
        for (int k = 0; k < 6; k++) begin
            if (vld[k]) drive(1'b1, w0(wrd[k]), w1(wrd[k]));
            else drive_gap();
            step();
            checks++; if (bus.dout_valid !== vld[k]) begin failures++; $display("FAIL gap_valid k=%0d got=%b exp=%b", k, bus.dout_valid, vld[k]); end
            checks++; if (bus.dout0 !== w0(e0[k])) begin failures++; $display("FAIL gap_dout0 k=%0d got=%h exp=%h", k, bus.dout0, w0(e0[k])); end
            checks++; if (bus.dout1 !== w1(e1[k])) begin failures++; $display("FAIL gap_dout1 k=%0d got=%h exp=%h", k, bus.dout1, w1(e1[k])); end
            if (!vld[k]) begin
                checks++; if (bus.am_ping !== 2'b00) begin failures++; $display("FAIL gap_am_ping k=%0d got=%b exp=00", k, bus.am_ping); end
            end
        end
    endtask

    task automatic test_wrap();
        unlock_clear();
        drive_gap();
        for (int p = 0; p < 15; p++) begin
            fallback_req = 2'b10;
            step();
            checks++; if (skew_ovf !== 2'b00) begin failures++; $display("FAIL wrap_pre_ovf p=%0d got=%b exp=00", p, skew_ovf); end
        end
        fallback_req = 2'b00;
        for (int n = 300; n < 316; n++) begin
            drive(1'b1, w0(n), w1(n));
            step();
        end
        checks++; if (bus.dout1 !== w1(300)) begin failures++; $display("FAIL wrap_d15_dout1 got=%h exp=%h", bus.dout1, w1(300)); end
        checks++; if (bus.dout0 !== w0(315)) begin failures++; $display("FAIL wrap_d15_dout0 got=%h exp=%h", bus.dout0, w0(315)); end
        drive_gap();
        fallback_req = 2'b10;
        step();
        checks++; if (skew_ovf !== 2'b10) begin failures++; $display("FAIL wrap_ovf got=%b exp=10", skew_ovf); end
        fallback_req = 2'b00;
        step();
        checks++; if (skew_ovf !== 2'b00) begin failures++; $display("FAIL wrap_ovf_clear got=%b exp=00", skew_ovf); end
        drive(1'b1, w0(316), w1(316));
        step();
        checks++; if (bus.dout1 !== w1(316)) begin failures++; $display("FAIL wrap_d0_dout1 got=%h exp=%h", bus.dout1, w1(316)); end
    endtask

    task automatic test_conflict_unlock();
        drive_gap();
        for (int p = 0; p < 5; p++) begin
            fallback_req = 2'b01;
            step();
        end
        fallback_req = 2'b11;
        step();
        checks++; if (skew_ovf !== 2'b00) begin failures++; $display("FAIL conflict_ovf got=%b exp=00", skew_ovf); end
        fallback_req = 2'b00;
        for (int n = 400; n < 406; n++) begin
            drive(1'b1, w0(n), w1(n));
            step();
        end
        checks++; if (bus.dout0 !== w0(400)) begin failures++; $display("FAIL conflict_dout0 got=%h exp=%h", bus.dout0, w0(400)); end
        checks++; if (bus.dout1 !== w1(405)) begin failures++; $display("FAIL conflict_dout1 got=%h exp=%h", bus.dout1, w1(405)); end
        word_locked = 1'b0;
        drive_gap();
        step();
        drive(1'b1, w0(406), w1(406));
        step();
        checks++; if (bus.dout0 !== w0(406)) begin failures++; $display("FAIL unlock_dout0 got=%h exp=%h", bus.dout0, w0(406)); end
        drive_gap();
        for (int p = 0; p < 3; p++) begin
            fallback_req = 2'b01;
            step();
        end
        fallback_req = 2'b00;
        drive(1'b1, w0(407), w1(407));
        step();
        checks++; if (bus.dout0 !== w0(407)) begin failures++; $display("FAIL unlock_ignore_dout0 got=%h exp=%h", bus.dout0, w0(407)); end
        word_locked = 1'b1;
        drive(1'b1, w0(408), w1(408));
        step();
        checks++; if (bus.dout0 !== w0(408)) begin failures++; $display("FAIL relock_dout0 got=%h exp=%h", bus.dout0, w0(408)); end
    endtask

`ifdef LANE_SKEW_STATS_EN
    task automatic test_stats();
        int exp_cnt;
        unlock_clear();
        drive_gap();
        checks++; if (fb_cnt0 !== 8'd0) begin failures++; $display("FAIL stats_init_cnt got=%0d exp=0", fb_cnt0); end
        for (int n = 1; n <= 300; n++) begin
            fallback_req = 2'b01;
            step();
            exp_cnt = (n > 255) ? 255 : n;
            checks++; if (delay0 !== 4'(n % 16)) begin failures++; $display("FAIL stats_delay0 n=%0d got=%0d exp=%0d", n, delay0, n % 16); end
            checks++; if (fb_cnt0 !== 8'(exp_cnt)) begin failures++; $display("FAIL stats_fb_cnt0 n=%0d got=%0d exp=%0d", n, fb_cnt0, exp_cnt); end
            checks++; if (fb_cnt1 !== 8'd0) begin failures++; $display("FAIL stats_fb_cnt1 n=%0d got=%0d exp=0", n, fb_cnt1); end
        end
        fallback_req = 2'b00;
        word_locked = 1'b0;
        step();
        checks++; if (fb_cnt0 !== 8'd0) begin failures++; $display("FAIL stats_unlock_cnt got=%0d exp=0", fb_cnt0); end
        checks++; if (delay0 !== 4'd0) begin failures++; $display("FAIL stats_unlock_delay got=%0d exp=0", delay0); end
        word_locked = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_skew3();
        test_valid_gaps();
        test_wrap();
        test_conflict_unlock();
`ifdef LANE_SKEW_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_skew_buf_2ln.md
Name: lane_skew_buf_2ln

Overview:
- Two-lane skew buffer that sits directly upstream of the two-lane deskew lock monitor.
- Per lane: a programmable word delay line plus an alignment-marker (AM) detector at the delay-line output.
- Produces per-lane am_ping pulses for the lock monitor.
- Consumes its per-lane fallback_req pulses to add one word of delay to the early lane, until markers on both lanes coincide.

Parameters:
- WORD_W, 64, lane word width in bits.
- MAX_SKEW, 16, delay-line depth in words; legal per-lane delay is 0..MAX_SKEW-1; power of 2, minimum 2.
- AM_LN0, 64'h90_76_47_6F_89_B8_B8_6F, lane 0 alignment-marker pattern.
- AM_LN1, 64'hF0_C4_E6_0F_3B_3B_19_F0, lane 1 alignment-marker pattern.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- word_locked  in  1  both lanes word-locked; low forces delays to 0.
- din_valid  in  1  din words valid this cycle (common to both lanes).
- din0  in  WORD_W  lane 0 input word.
- din1  in  WORD_W  lane 1 input word.
- fallback_req  in  2  per-lane one-cycle pulse: lane is early, add one word of delay.
- dout_valid  out  1  dout words valid.
- dout0  out  WORD_W  lane 0 delayed word.
- dout1  out  WORD_W  lane 1 delayed word.
- am_ping  out  2  per-lane pulse, high with the dout word that equals that lane's AM pattern.
- skew_ovf  out  2  per-lane one-cycle pulse, delay wrapped from MAX_SKEW-1 to 0.

Behaviour:
- Reset (arst_n low, asynchronous): clears delay counters, dout_valid, dout0/1, am_ping and skew_ovf to 0. Delay-line contents are not reset.
- Shift: each lane's delay line shifts one position only on cycles where din_valid=1. Delay is counted in valid words, not clock cycles.
- Output: on a din_valid cycle, dout_valid rises next cycle. dout_i = lane i word written d_i valid words earlier (tap d_i); d_i=0 gives 1 cycle latency.
- Output hold: dout is registered and holds its value when din_valid=0; dout_valid=0 on those cycles.
- am_ping[i]: registered alongside dout_i; equals (tap word == AM pattern) and din_valid. Never high when dout_valid is low.
- Delay counter d_i, width clog2(MAX_SKEW):
  - word_locked=0: d_i forced to 0 each cycle; fallback_req ignored.
  - fallback_req[i]=1, the other bit 0, d_i<MAX_SKEW-1: d_i+1 next cycle.
  - fallback_req[i]=1, the other bit 0, d_i=MAX_SKEW-1: d_i becomes 0 and skew_ovf[i] pulses for 1 cycle.
  - fallback_req=2'b11: both ignored (contradictory request); no change.
- Request arriving on a din_valid=0 cycle: still applied.
- Delay increase while streaming: the next valid output repeats the previous word (one duplicate). Acceptable because the deskew monitor is unlocked whenever it requests fallback.
- Mid-stream reset: outputs drop immediately. After release, output is garbage until MAX_SKEW valid words have shifted in; am_ping on garbage is harmless.

Optional Feature:
- Macro: LANE_SKEW_STATS_EN.
- Defined, adds outputs:
  - delay0 and delay1 (clog2(MAX_SKEW) bits): the current d_i.
  - fb_cnt0 and fb_cnt1 (8 bits): saturating counts of applied fallback increments, wraps included.
  - The counters are cleared by reset and by word_locked=0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package: default AM patterns for lanes 0..3 and a DELAY_W = clog2(MAX_SKEW) helper function.
- One sub-module, lane_skew_line: a single-lane delay line, tap mux, delay counter with wrap/ovf, and AM compare.
- lane_skew_buf_2ln instantiates lane_skew_line twice; the top handles the 2'b11 reject and the word_locked force.

Test Plan:
1. Reset and flush: arst_n low mid-stream -> dout_valid, am_ping and skew_ovf are 0 the same cycle. After release with word_locked=1 and continuous din_valid, dout0 equals din0 one cycle late.
2. Skew 3 correction: lane 1 AM injected 3 words after lane 0 AM; pulse fallback_req[0] three times -> d0=3. Next AM pair gives am_ping=2'b11 in the same cycle.
3. Valid gaps: din_valid pattern 1,0,1,1,0,1 with d0=2 -> dout0 follows in valid-word order; dout_valid mirrors din_valid one cycle late; dout holds during gaps.
4. Wrap: MAX_SKEW=16, d1=15, pulse fallback_req[1] -> d1=0 and skew_ovf=2'b10 for exactly 1 cycle.
5. Conflict and unlock: fallback_req=2'b11 -> no delay change. Then word_locked=0 with d0=5 -> d0=0 next cycle; fallback pulses are ignored while unlocked.
6. LANE_SKEW_STATS_EN: 300 fallback_req[0] pulses -> fb_cnt0 saturates at 255; delay0 tracks d0, including wraps.
